// File: rtl/riscv_writeback_pkg.sv
// Package riscv_def: definitions shared by the write-back stage files.
//   INST_MUL*      : mask/match encodings of the RV32M multiply instructions
//                    (MUL, MULH, MULHSU, MULHU), used to tag MUL-class ops.
//   WB_XLEN/WB_REG_AW : widths of the stage record; the riscv_writeback
//                    XLEN/REG_AW parameters must be kept equal to these.
//   wb_stage_t     : one pipeline slot {valid, is_mul, rd, data}.
//   is_mul_op()    : true when an instruction word is MUL-class.
package riscv_def;

  localparam int WB_XLEN   = 32;
  localparam int WB_REG_AW = 5;

  localparam logic [31:0] INST_MUL_MASK    = 32'hfe00_707f;
  localparam logic [31:0] INST_MUL_MATCH   = 32'h0200_0033;
  localparam logic [31:0] INST_MULH_MATCH  = 32'h0200_1033;
  localparam logic [31:0] INST_MULHSU_MATCH = 32'h0200_2033;
  localparam logic [31:0] INST_MULHU_MATCH = 32'h0200_3033;

  typedef struct packed {
    logic                 valid;
    logic                 is_mul;
    logic [WB_REG_AW-1:0] rd;
    logic [WB_XLEN-1:0]   data;
  } wb_stage_t;

  function automatic logic is_mul_op(input logic [31:0] op);
    logic [31:0] masked;
    masked = op & INST_MUL_MASK;
    return (masked == INST_MUL_MATCH)    || (masked == INST_MULH_MATCH) ||
           (masked == INST_MULHSU_MATCH) || (masked == INST_MULHU_MATCH);
  endfunction

endpackage

// File: rtl/riscv_wb_skid.sv
// riscv_wb_skid: one-entry skid buffer for out-of-band load responses.
// Ports:
//   clk, srst_n              : clock, synchronous active-low reset
//   lsu_valid_i/rd_i/data_i  : load response from the LSU
//   lsu_ready_o              : response consumed this cycle
//   port_busy_i              : write port unavailable to a new load
//                              (s2 writing or pipeline held)
//   s2_wr_i                  : s2 owns the write port this cycle
//   buf_valid_o              : buffer holds a load
//   wr_valid_o/rd_o/data_o   : load write request towards the register file
//
// Handshake: a response transfers in any cycle where lsu_valid_i and
// lsu_ready_o are both high; ready depends only on the buffer state, never
// on lsu_valid_i, and the LSU must hold rd/data stable until the transfer.
module riscv_wb_skid #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              lsu_valid_i,
  input  logic [REG_AW-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]   lsu_data_i,
  output logic              lsu_ready_o,
  input  logic              port_busy_i,
  input  logic              s2_wr_i,
  output logic              buf_valid_o,
  output logic              wr_valid_o,
  output logic [REG_AW-1:0] wr_rd_o,
  output logic [XLEN-1:0]   wr_data_o
);

  logic              buf_valid_q;
  logic [REG_AW-1:0] buf_rd_q;
  logic [XLEN-1:0]   buf_data_q;

  logic accept;
  logic keep;
  logic pass;
  logic drain;

  assign accept = lsu_valid_i & ~buf_valid_q;
  // Loads to x0 are consumed but never buffered or written.
  assign keep   = (lsu_rd_i != '0);
  assign pass   = accept & keep & ~port_busy_i;
  // The buffer yields only to an s2 write; it may drain while held.
  assign drain  = buf_valid_q & ~s2_wr_i;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      buf_valid_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_data_q  <= '0;
    end else if (drain) begin
      buf_valid_q <= 1'b0;
    end else if (accept && keep && port_busy_i) begin
      buf_valid_q <= 1'b1;
      buf_rd_q    <= lsu_rd_i;
      buf_data_q  <= lsu_data_i;
    end
  end

  assign lsu_ready_o = ~buf_valid_q;
  assign buf_valid_o = buf_valid_q;
  assign wr_valid_o  = drain | pass;
  // While the buffer is full these carry the buffered entry, which the
  // forwarding logic relies on.
  assign wr_rd_o     = buf_valid_q ? buf_rd_q   : lsu_rd_i;
  assign wr_data_o   = buf_valid_q ? buf_data_q : lsu_data_i;

endmodule

// File: rtl/riscv_writeback.sv
// riscv_writeback: result write-back stage after the ALU and riscv_mul.
// Every issued instruction is written exactly two unheld cycles after issue,
// lining the ALU result up with the registered multiplier output. Load
// responses use free write slots through riscv_wb_skid.
// Ports:
//   clk, srst_n           : clock, synchronous active-low reset
//   hold                  : pipeline freeze (shared with riscv_mul)
//   issue_*               : issued instruction (valid, opcode, rd, ALU result)
//   mul_result_i          : riscv_mul result, valid while the op sits in s2
//   lsu_valid_i/rd/data   : load response; lsu_ready_o accepts it
//   rs1_i/rs2_i, rs*_data_i : issue-stage sources and register-file data
//   rs*_data_o, stall_o   : forwarded operands and issue stall
//   rf_we_o/waddr_o/wdata_o : register-file write port
// Build option RISCV_WB_BYPASS_EN: when defined, operands are forwarded from
// s1/s2/the load buffer; otherwise any dependency on them stalls issue.
// The issue stage must keep issue_valid_i low while stall_o is high.
module riscv_writeback
  import riscv_def::*;
#(
  parameter int XLEN   = WB_XLEN,
  parameter int REG_AW = WB_REG_AW
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              hold,
  input  logic              issue_valid_i,
  input  logic [31:0]       issue_opcode_i,
  input  logic [REG_AW-1:0] issue_rd_i,
  input  logic [XLEN-1:0]   issue_alu_result_i,
  input  logic [XLEN-1:0]   mul_result_i,
  input  logic              lsu_valid_i,
  input  logic [REG_AW-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]   lsu_data_i,
  output logic              lsu_ready_o,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic              stall_o,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [XLEN-1:0]   rf_wdata_o
);

  wb_stage_t s1_q, s2_q, s1_d;

  logic              s2_wr;
  logic [XLEN-1:0]   s2_data;
  logic              buf_valid;
  logic              lsu_wr_valid;
  logic [REG_AW-1:0] lsu_wr_rd;
  logic [XLEN-1:0]   lsu_wr_data;

  // Writes to x0 are dropped at capture so they are never tracked.
  always_comb begin
    s1_d        = '0;
    s1_d.valid  = issue_valid_i && (issue_rd_i != '0);
    s1_d.is_mul = is_mul_op(issue_opcode_i);
    s1_d.rd     = issue_rd_i;
    s1_d.data   = issue_alu_result_i;
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (!hold) begin
      s1_q <= s1_d;
      s2_q <= s1_q;
    end
  end

  // A held s2 write is retried when hold drops; riscv_mul keeps its output.
  assign s2_wr   = s2_q.valid & ~hold;
  assign s2_data = s2_q.is_mul ? mul_result_i : s2_q.data;

  riscv_wb_skid #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_skid (
    .clk         (clk),
    .srst_n      (srst_n),
    .lsu_valid_i (lsu_valid_i),
    .lsu_rd_i    (lsu_rd_i),
    .lsu_data_i  (lsu_data_i),
    .lsu_ready_o (lsu_ready_o),
    .port_busy_i (s2_wr | hold),
    .s2_wr_i     (s2_wr),
    .buf_valid_o (buf_valid),
    .wr_valid_o  (lsu_wr_valid),
    .wr_rd_o     (lsu_wr_rd),
    .wr_data_o   (lsu_wr_data)
  );

  // s2 has priority; loads take the remaining slots. Writes are masked
  // while reset is asserted so in-flight results never land.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (srst_n) begin
      if (s2_wr) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = s2_q.rd;
        rf_wdata_o = s2_data;
      end else if (lsu_wr_valid) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = lsu_wr_rd;
        rf_wdata_o = lsu_wr_data;
      end
    end
  end

  function automatic logic hit(input logic v, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] rs);
    return v && (rs != '0) && (rd == rs);
  endfunction

  logic [REG_AW-1:0] rs_addr [2];
  logic [XLEN-1:0]   rs_rf   [2];
  logic [XLEN-1:0]   rs_out  [2];
  logic [1:0]        rs_stall;

  // Per operand, the youngest producer wins: s1, then s2, then the buffer.
  always_comb begin
    rs_addr[0] = rs1_i;
    rs_addr[1] = rs2_i;
    rs_rf[0]   = rs1_data_i;
    rs_rf[1]   = rs2_data_i;
    rs_stall   = '0;
    for (int i = 0; i < 2; i++) begin
      rs_out[i] = rs_rf[i];
`ifdef RISCV_WB_BYPASS_EN
      if (hit(s1_q.valid, s1_q.rd, rs_addr[i])) begin
        // The product is not available until the op reaches s2.
        if (s1_q.is_mul) rs_stall[i] = 1'b1;
        else             rs_out[i]   = s1_q.data;
      end else if (hit(s2_q.valid, s2_q.rd, rs_addr[i])) begin
        rs_out[i] = s2_data;
      end else if (hit(buf_valid, lsu_wr_rd, rs_addr[i])) begin
        rs_out[i] = lsu_wr_data;
      end
`else
      rs_stall[i] = hit(s1_q.valid, s1_q.rd, rs_addr[i]) ||
                    hit(s2_q.valid, s2_q.rd, rs_addr[i]) ||
                    hit(buf_valid, lsu_wr_rd, rs_addr[i]);
`endif
    end
  end

  assign rs1_data_o = rs_out[0];
  assign rs2_data_o = rs_out[1];
  assign stall_o    = |rs_stall;

endmodule

// File: tb/tb_riscv_writeback.sv
// Directed bench for riscv_writeback: issue-to-write alignment, hold,
// load skid buffer, forwarding/stall (both build options) and reset.
module tb_riscv_writeback;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam logic [31:0] OP_ADD  = 32'h0000_0033;
  localparam logic [31:0] OP_MUL  = 32'h0200_0033;
  localparam logic [31:0] OP_MULH = 32'h0200_1033;
`ifdef RISCV_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              srst_n;
  logic              hold;
  logic              issue_valid_i;
  logic [31:0]       issue_opcode_i;
  logic [REG_AW-1:0] issue_rd_i;
  logic [XLEN-1:0]   issue_alu_result_i;
  logic [XLEN-1:0]   mul_result_i;
  logic              lsu_valid_i;
  logic [REG_AW-1:0] lsu_rd_i;
  logic [XLEN-1:0]   lsu_data_i;
  logic              lsu_ready_o;
  logic [REG_AW-1:0] rs1_i, rs2_i;
  logic [XLEN-1:0]   rs1_data_i, rs2_data_i;
  logic [XLEN-1:0]   rs1_data_o, rs2_data_o;
  logic              stall_o;
  logic              rf_we_o;
  logic [REG_AW-1:0] rf_waddr_o;
  logic [XLEN-1:0]   rf_wdata_o;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_writeback #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk                (clk),
    .srst_n             (srst_n),
    .hold               (hold),
    .issue_valid_i      (issue_valid_i),
    .issue_opcode_i     (issue_opcode_i),
    .issue_rd_i         (issue_rd_i),
    .issue_alu_result_i (issue_alu_result_i),
    .mul_result_i       (mul_result_i),
    .lsu_valid_i        (lsu_valid_i),
    .lsu_rd_i           (lsu_rd_i),
    .lsu_data_i         (lsu_data_i),
    .lsu_ready_o        (lsu_ready_o),
    .rs1_i              (rs1_i),
    .rs2_i              (rs2_i),
    .rs1_data_i         (rs1_data_i),
    .rs2_data_i         (rs2_data_i),
    .rs1_data_o         (rs1_data_o),
    .rs2_data_o         (rs2_data_o),
    .stall_o            (stall_o),
    .rf_we_o            (rf_we_o),
    .rf_waddr_o         (rf_waddr_o),
    .rf_wdata_o         (rf_wdata_o)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] op, input logic [REG_AW-1:0] rd,
                       input logic [XLEN-1:0] alu);
    issue_valid_i      = 1'b1;
    issue_opcode_i     = op;
    issue_rd_i         = rd;
    issue_alu_result_i = alu;
  endtask

  task automatic idle();
    issue_valid_i      = 1'b0;
    issue_opcode_i     = 32'h0;
    issue_rd_i         = '0;
    issue_alu_result_i = '0;
  endtask

  task automatic lsu(input logic v, input logic [REG_AW-1:0] rd,
                     input logic [XLEN-1:0] data);
    lsu_valid_i = v;
    lsu_rd_i    = rd;
    lsu_data_i  = data;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic [REG_AW-1:0] addr,
                          input logic [XLEN-1:0] data);
    check({tag, "_we"}, 32'(rf_we_o), 32'd1);
    check({tag, "_waddr"}, 32'(rf_waddr_o), 32'(addr));
    check({tag, "_wdata"}, rf_wdata_o, data);
  endtask

  initial begin
    srst_n = 1'b0;
    hold   = 1'b0;
    idle();
    mul_result_i = '0;
    lsu(1'b0, '0, '0);
    rs1_i = '0; rs2_i = '0; rs1_data_i = '0; rs2_data_i = '0;

    // Reset state
    cyc(); cyc();
    #1;
    check("rst_we",    32'(rf_we_o), 32'd0);
    check("rst_waddr", 32'(rf_waddr_o), 32'd0);
    check("rst_wdata", rf_wdata_o, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_ready", 32'(lsu_ready_o), 32'd1);
    srst_n = 1'b1;

    // ALU add to x5, written two cycles after issue
    cyc(); issue(OP_ADD, 5'd5, 32'h0000_0011);
    cyc(); idle(); #1;
    check("alu_n1_we", 32'(rf_we_o), 32'd0);
    cyc(); #1;
    check_wr("alu_n2", 5'd5, 32'h0000_0011);

    // MULH to x7 then back-to-back ALU to x8
    cyc(); issue(OP_MULH, 5'd7, 32'h0000_0005);
    cyc(); issue(OP_ADD, 5'd8, 32'h0000_0088);
    cyc(); idle(); mul_result_i = 32'hFFFF_FFFF; #1;
    check_wr("mulh_n2", 5'd7, 32'hFFFF_FFFF);
    cyc(); mul_result_i = 32'h0000_1234; #1;
    check_wr("alu_n3", 5'd8, 32'h0000_0088);

    // Hold for 3 cycles with a MUL in s2; issue during hold is ignored
    cyc(); issue(OP_MUL, 5'd10, 32'h0);
    cyc(); idle();
    cyc(); hold = 1'b1; mul_result_i = 32'hCAFE_0001;
    issue(OP_ADD, 5'd11, 32'h0000_0099); #1;
    check("hold0_we", 32'(rf_we_o), 32'd0);
    cyc(); #1;
    check("hold1_we", 32'(rf_we_o), 32'd0);
    cyc(); #1;
    check("hold2_we", 32'(rf_we_o), 32'd0);
    cyc(); hold = 1'b0; idle(); #1;
    check_wr("hold_rel", 5'd10, 32'hCAFE_0001);
    cyc(); #1;
    check("hold_ignored_issue", 32'(rf_we_o), 32'd0);

    // Load colliding with an s2 write goes through the buffer
    cyc(); issue(OP_ADD, 5'd12, 32'h0000_0055);
    cyc(); idle();
    cyc(); lsu(1'b1, 5'd9, 32'hDEAD_BEEF); #1;
    check("ld_coll_ready", 32'(lsu_ready_o), 32'd1);
    check_wr("ld_coll_s2", 5'd12, 32'h0000_0055);
    cyc(); lsu(1'b0, '0, '0); #1;
    check("ld_buf_ready", 32'(lsu_ready_o), 32'd0);
    check_wr("ld_buf", 5'd9, 32'hDEAD_BEEF);
    cyc(); #1;
    check("ld_empty_ready", 32'(lsu_ready_o), 32'd1);
    check("ld_empty_we", 32'(rf_we_o), 32'd0);
    // Pass-through on a free port, then a load to x0 is dropped
    lsu(1'b1, 5'd13, 32'h0000_0077); #1;
    check_wr("ld_pass", 5'd13, 32'h0000_0077);
    cyc(); lsu(1'b1, 5'd0, 32'h0000_0005); #1;
    check("ld_x0_we", 32'(rf_we_o), 32'd0);
    check("ld_x0_ready", 32'(lsu_ready_o), 32'd1);
    cyc(); lsu(1'b0, '0, '0); #1;
    check("ld_x0_after_we", 32'(rf_we_o), 32'd0);
    check("ld_x0_after_ready", 32'(lsu_ready_o), 32'd1);

    // Full buffer + s2 write + new load: load waits, buffer forwards
    cyc(); issue(OP_ADD, 5'd14, 32'h0000_000E);
    cyc(); issue(OP_ADD, 5'd15, 32'h0000_000F);
    cyc(); idle(); lsu(1'b1, 5'd16, 32'h0000_000A); #1;
    check_wr("full_s2a", 5'd14, 32'h0000_000E);
    cyc(); lsu(1'b1, 5'd17, 32'h0000_000B);
    rs1_i = 5'd16; rs1_data_i = 32'h0000_0BAD; #1;
    check("full_ready", 32'(lsu_ready_o), 32'd0);
    check_wr("full_s2b", 5'd15, 32'h0000_000F);
    check("fwd_buf_data", rs1_data_o, BYP ? 32'h0000_000A : 32'h0000_0BAD);
    check("fwd_buf_stall", 32'(stall_o), BYP ? 32'd0 : 32'd1);
    cyc(); rs1_i = '0; #1;
    check("drain_ready", 32'(lsu_ready_o), 32'd0);
    check_wr("drain", 5'd16, 32'h0000_000A);
    cyc(); #1;
    check("wait_ready", 32'(lsu_ready_o), 32'd1);
    check_wr("wait_pass", 5'd17, 32'h0000_000B);
    cyc(); lsu(1'b0, '0, '0); #1;
    check("wait_done_we", 32'(rf_we_o), 32'd0);

    // Dependent on a MUL in s1
    cyc(); issue(OP_MUL, 5'd20, 32'h0);
    cyc(); idle(); rs1_i = 5'd20; rs1_data_i = 32'h0000_0BAD; #1;
    check("mul_s1_stall", 32'(stall_o), 32'd1);
    check("mul_s1_data", rs1_data_o, 32'h0000_0BAD);
    cyc(); mul_result_i = 32'h0000_0600; #1;
    check("mul_s2_stall", 32'(stall_o), BYP ? 32'd0 : 32'd1);
    check("mul_s2_data", rs1_data_o, BYP ? 32'h0000_0600 : 32'h0000_0BAD);
    cyc(); #1;
    check("mul_done_stall", 32'(stall_o), 32'd0);
    check("mul_done_data", rs1_data_o, 32'h0000_0BAD);
    rs1_i = '0;

    // Dependent on an ALU op in s1
    cyc(); issue(OP_ADD, 5'd21, 32'h0000_0321);
    cyc(); idle(); rs2_i = 5'd21; rs2_data_i = 32'h0000_0BA2; #1;
    check("alu_s1_stall", 32'(stall_o), BYP ? 32'd0 : 32'd1);
    check("alu_s1_data", rs2_data_o, BYP ? 32'h0000_0321 : 32'h0000_0BA2);

    // Same rd in s1 and s2: youngest (s1) wins
    cyc(); rs2_i = '0; issue(OP_ADD, 5'd22, 32'h0000_0001);
    cyc(); issue(OP_ADD, 5'd22, 32'h0000_0002);
    cyc(); idle(); rs1_i = 5'd22; rs1_data_i = 32'h0000_0BAD; #1;
    check("young_data", rs1_data_o, BYP ? 32'h0000_0002 : 32'h0000_0BAD);
    check("young_stall", 32'(stall_o), BYP ? 32'd0 : 32'd1);
    check_wr("young_s2", 5'd22, 32'h0000_0001);
    rs1_i = '0;

    // Reset with s1, s2 and the buffer all valid
    cyc(); issue(OP_ADD, 5'd23, 32'h0000_0023);
    cyc(); issue(OP_ADD, 5'd24, 32'h0000_0024);
    cyc(); issue(OP_ADD, 5'd26, 32'h0000_0026); lsu(1'b1, 5'd25, 32'h0000_0025);
    cyc(); idle(); lsu(1'b0, '0, '0); srst_n = 1'b0;
    cyc(); srst_n = 1'b1; #1;
    check("mrst_we0", 32'(rf_we_o), 32'd0);
    check("mrst_ready", 32'(lsu_ready_o), 32'd1);
    check("mrst_stall", 32'(stall_o), 32'd0);
    cyc(); #1;
    check("mrst_we1", 32'(rf_we_o), 32'd0);
    cyc(); #1;
    check("mrst_we2", 32'(rf_we_o), 32'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
